// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus cycle controller placed after the MMU.
// Starts the MMU lookup, decodes the translated page, drives one chip select
// with per-region wait states, and ends the cycle with DTACK or BERR.
// Build option: define ROM_WRITE_PROTECT_EN to turn ROM writes into bus errors.
module bus_cycle_ctrl #(
    parameter int unsigned MMU_LAT    = 1,
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned ROM_WAIT   = 2,
    parameter int unsigned GFX_WAIT   = 1,
    parameter int unsigned IO_WAIT    = 3,
    parameter int unsigned IO_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        rw,
    input  logic [15:0] phys_addr,
    input  logic        io_ready,
    output logic        mmu_en,
    output logic        ram_cs_n,
    output logic        rom_cs_n,
    output logic        gfx_cs_n,
    output logic        board_cs_n,
    output logic        ptab_cs_n,
    output logic        pio_cs_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        dtack_n,
    output logic        berr_n
);

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned TO_W   = 8;
    localparam int unsigned LAT_W  = 3;

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MMU_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IO_TIMEOUT - 1);

`ifdef ROM_WRITE_PROTECT_EN
    localparam logic ROM_WP = 1'b1;
`else
    localparam logic ROM_WP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ACCESS,
        S_ACK,
        S_BERR
    } state_t;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_RAM,
        RG_ROM,
        RG_GFX,
        RG_BOARD,
        RG_PTAB,
        RG_PIO
    } region_t;

    state_t              state_q, state_d;
    region_t             region_q, region_d;
    logic                rw_q, rw_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                sel_d;
    logic                blocked;
    region_t             dec_region;
    logic                unused_pa;

    // Only the upper byte of the page address takes part in the decode.
    assign unused_pa = ^phys_addr[7:0];

    // Page address to physical region.
    function automatic region_t decode(input logic [7:0] pa_hi);
        if (pa_hi[7])                      return RG_RAM;
        else if (pa_hi[7:6] == 2'b01)      return RG_ROM;
        else if (pa_hi[7:2] == 6'b000011)  return RG_GFX;
        else if (pa_hi == 8'h01)           return RG_BOARD;
        else if (pa_hi == 8'h02)           return RG_PTAB;
        else if (pa_hi == 8'h03)           return RG_PIO;
        else                               return RG_NONE;
    endfunction

    // Minimum wait states for each region.
    function automatic logic [WAIT_W-1:0] region_wait(input region_t rg);
        case (rg)
            RG_RAM:  return WAIT_W'(RAM_WAIT);
            RG_ROM:  return WAIT_W'(ROM_WAIT);
            RG_GFX:  return WAIT_W'(GFX_WAIT);
            default: return WAIT_W'(IO_WAIT);
        endcase
    endfunction

    function automatic logic is_io(input region_t rg);
        return (rg == RG_BOARD) || (rg == RG_PTAB) || (rg == RG_PIO);
    endfunction

    assign dec_region = decode(phys_addr[15:8]);
    assign blocked    = (dec_region == RG_NONE) ||
                        (ROM_WP && (dec_region == RG_ROM) && !rw_q);

    // Next-state logic for the bus cycle sequencer.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        rw_d     = rw_q;
        lat_d    = lat_q;
        wait_d   = wait_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (!as_n) begin
                    state_d  = S_LOOKUP;
                    rw_d     = rw;
                    lat_d    = LAT_LOAD;
                    region_d = RG_NONE;
                end
            end
            S_LOOKUP: begin
                if (as_n) begin
                    state_d = S_IDLE;
                end else if (lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                end else if (blocked) begin
                    state_d  = S_BERR;
                    region_d = RG_NONE;
                end else begin
                    state_d  = S_ACCESS;
                    region_d = dec_region;
                    wait_d   = region_wait(dec_region);
                    to_d     = '0;
                end
            end
            S_ACCESS: begin
                if (as_n) begin
                    state_d = S_IDLE;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (!is_io(region_q) || io_ready) begin
                    state_d = S_ACK;
                end else if (to_q >= TO_LAST) begin
                    state_d = S_BERR;
                end else if (to_q != '1) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_ACK, S_BERR: begin
                if (as_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel_d = (state_d == S_ACCESS) || (state_d == S_ACK);

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            region_q   <= RG_NONE;
            rw_q       <= 1'b1;
            lat_q      <= '0;
            wait_q     <= '0;
            to_q       <= '0;
            mmu_en     <= 1'b0;
            ram_cs_n   <= 1'b1;
            rom_cs_n   <= 1'b1;
            gfx_cs_n   <= 1'b1;
            board_cs_n <= 1'b1;
            ptab_cs_n  <= 1'b1;
            pio_cs_n   <= 1'b1;
            oe_n       <= 1'b1;
            we_n       <= 1'b1;
            dtack_n    <= 1'b1;
            berr_n     <= 1'b1;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            rw_q       <= rw_d;
            lat_q      <= lat_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            mmu_en     <= (state_d == S_LOOKUP);
            ram_cs_n   <= !(sel_d && (region_d == RG_RAM));
            rom_cs_n   <= !(sel_d && (region_d == RG_ROM));
            gfx_cs_n   <= !(sel_d && (region_d == RG_GFX));
            board_cs_n <= !(sel_d && (region_d == RG_BOARD));
            ptab_cs_n  <= !(sel_d && (region_d == RG_PTAB));
            pio_cs_n   <= !(sel_d && (region_d == RG_PIO));
            oe_n       <= !(sel_d && rw_d);
            // ROM never sees a write strobe; an unprotected ROM write is discarded.
            we_n       <= !(sel_d && !rw_d && (region_d != RG_ROM));
            dtack_n    <= !(state_d == S_ACK);
            berr_n     <= !(state_d == S_BERR);
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: a driver issues bus cycles and pushes
// the expected per-cycle summary; a monitor reconstructs each cycle from the
// pins and compares it against the queue.
module tb_bus_cycle_ctrl;

    localparam int MMU_LAT    = 1;
    localparam int IO_TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        reset, as_n, rw, io_ready;
    logic [15:0] phys_addr;
    logic        mmu_en, ram_cs_n, rom_cs_n, gfx_cs_n, board_cs_n, ptab_cs_n, pio_cs_n;
    logic        oe_n, we_n, dtack_n, berr_n;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(
        .MMU_LAT(1), .RAM_WAIT(0), .ROM_WAIT(2), .GFX_WAIT(1), .IO_WAIT(3), .IO_TIMEOUT(63)
    ) dut (
        .clk(clk), .reset(reset), .as_n(as_n), .rw(rw), .phys_addr(phys_addr),
        .io_ready(io_ready), .mmu_en(mmu_en), .ram_cs_n(ram_cs_n), .rom_cs_n(rom_cs_n),
        .gfx_cs_n(gfx_cs_n), .board_cs_n(board_cs_n), .ptab_cs_n(ptab_cs_n),
        .pio_cs_n(pio_cs_n), .oe_n(oe_n), .we_n(we_n), .dtack_n(dtack_n), .berr_n(berr_n)
    );

    // kind: 0 = no response (aborted), 1 = dtack, 2 = berr
    typedef struct {
        int       kind;
        int       lat;
        int       mmu_cnt;
        logic [5:0] cs;
        bit       oe;
        bit       we;
        int       end_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 0;
    bit   mon_active = 0;
    int   waits[6] = '{0, 2, 1, 3, 3, 3};
    logic [15:0] pool[16] = '{16'h8000, 16'hffff, 16'h4001, 16'h7fff, 16'h0c00, 16'h0fff,
                              16'h0100, 16'h01ff, 16'h0200, 16'h0300, 16'h03ff, 16'h0000,
                              16'h2000, 16'h3c00, 16'h0bff, 16'h0400};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Region index 0..5 = RAM, ROM, GFX, BOARD, PTAB, PIO; -1 = unmapped.
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'h8000)                       return 0;
        else if (a >= 16'h4000)                  return 1;
        else if (a >= 16'h0c00 && a <= 16'h0fff) return 2;
        else if (a >= 16'h0100 && a <= 16'h01ff) return 3;
        else if (a >= 16'h0200 && a <= 16'h02ff) return 4;
        else if (a >= 16'h0300 && a <= 16'h03ff) return 5;
        else                                     return -1;
    endfunction

    // Edge indices count posedges from the one that first samples as_n low (0).
    // r = first edge at which io_ready is high; ae = edge sampling release/reset.
    function automatic exp_t model(input logic [15:0] a, input bit rd, input int r, input int ae);
        exp_t e;
        int rg, w, t, resp;
        bit blocked;
        rg = region_of(a);
        blocked = (rg < 0);
`ifdef ROM_WRITE_PROTECT_EN
        if (rg == 1 && !rd) blocked = 1;
`endif
        if (blocked) begin
            resp = MMU_LAT;
            e.kind = 2;
        end else begin
            w = waits[rg];
            if (rg >= 3) begin
                t = r - (MMU_LAT + w + 1);
                if (t < 0) t = 0;
                if (t > IO_TIMEOUT - 1) begin
                    resp = MMU_LAT + w + IO_TIMEOUT;
                    e.kind = 2;
                end else begin
                    resp = MMU_LAT + w + 1 + t;
                    e.kind = 1;
                end
            end else begin
                resp = MMU_LAT + w + 1;
                e.kind = 1;
            end
        end
        e.lat = resp;
        e.mmu_cnt = (ae < MMU_LAT) ? ae : MMU_LAT;
        e.end_n = ae;
        if (ae <= resp) e.kind = 0;
        if (!blocked && ae > MMU_LAT) begin
            e.cs = 6'(1 << rg);
            e.oe = rd;
            e.we = !rd && (rg != 1);
        end else begin
            e.cs = '0;
            e.oe = 0;
            e.we = 0;
        end
        return e;
    endfunction

    // Caller is positioned just after a posedge.
    task automatic run_txn(input logic [15:0] a, input bit rd, input int r, input int ae,
                           input bit use_rst, input int gap);
        sb.push_back(model(a, rd, r, ae));
        phys_addr = a;
        rw = rd;
        as_n = 1'b0;
        for (int k = 0; k <= ae; k++) begin
            io_ready = (k >= r);
            if (k == ae) begin
                if (use_rst) reset = 1'b1;
                else         as_n = 1'b1;
            end
            @(posedge clk); #1;
            if (k == 0) rw = 1'($urandom);
            if (k == MMU_LAT) phys_addr = 16'($urandom);
        end
        reset = 1'b0;
        as_n = 1'b1;
        io_ready = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: rebuild each bus cycle from the pins and score it.
    initial begin
        int n, okind, olat, ommu;
        bit ooe, owe;
        logic [5:0] cs, cs_or;
        exp_t e;
        n = 0; okind = 0; olat = 0; ommu = 0; ooe = 0; owe = 0; cs_or = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cs = ~{pio_cs_n, ptab_cs_n, board_cs_n, gfx_cs_n, rom_cs_n, ram_cs_n};
                chk("cs_onehot", int'($countones(cs) <= 1), 1);
                chk("dtack_berr_excl", int'(!(!dtack_n && !berr_n)), 1);
                chk("strobe_excl", int'(!(!oe_n && !we_n)), 1);
                if (!mon_active && mmu_en) begin
                    mon_active = 1; n = 0; okind = 0; olat = 0; ommu = 0;
                    ooe = 0; owe = 0; cs_or = '0;
                end else if (mon_active) begin
                    n++;
                end
                if (mon_active) begin
                    ommu += int'(mmu_en);
                    cs_or |= cs;
                    ooe |= !oe_n;
                    owe |= !we_n;
                    if (okind == 0 && !dtack_n) begin okind = 1; olat = n; end
                    else if (okind == 0 && !berr_n) begin okind = 2; olat = n; end
                    if (!mmu_en && cs == '0 && oe_n && we_n && dtack_n && berr_n) begin
                        mon_active = 0;
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_cycle actual=1 required=0 at %0t", $time);
                        end else begin
                            e = sb.pop_front();
                            chk("response_kind", okind, e.kind);
                            if (e.kind != 0) chk("response_latency", olat, e.lat);
                            chk("mmu_en_cycles", ommu, e.mmu_cnt);
                            chk("chip_selects", int'(cs_or), int'(e.cs));
                            chk("oe_seen", int'(ooe), int'(e.oe));
                            chk("we_seen", int'(owe), int'(e.we));
                            chk("cycle_end", n, e.end_n);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t pe;
        logic [15:0] a;
        bit rd, rst;
        int r, ae;
        reset = 1'b1; as_n = 1'b1; rw = 1'b1; io_ready = 1'b0; phys_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            int'({mmu_en, ram_cs_n, rom_cs_n, gfx_cs_n, board_cs_n, ptab_cs_n, pio_cs_n,
                  oe_n, we_n, dtack_n, berr_n}), int'(11'b0_111111_1111));
        @(posedge clk); #1;
        reset = 1'b0;
        mon_on = 1;
        @(posedge clk); #1;

        run_txn(16'h8000, 1, 0, 3, 0, 1);    // RAM read
        run_txn(16'h8000, 1, 0, 2, 1, 1);    // reset during RAM access
        run_txn(16'h8000, 0, 0, 4, 0, 0);    // fresh RAM write after reset
        run_txn(16'h4001, 1, 0, 6, 0, 1);    // ROM read
        run_txn(16'h4001, 0, 0, 6, 0, 1);    // ROM write
        run_txn(16'h0300, 0, 10, 12, 0, 1);  // PIO write, io_ready 5 cycles late
        run_txn(16'h0300, 0, 1000, 69, 0, 1); // PIO timeout
        run_txn(16'h0000, 1, 0, 3, 0, 1);    // unmapped
        run_txn(16'h2000, 0, 0, 4, 0, 0);    // unmapped, back-to-back
        run_txn(16'h8000, 1, 0, 1, 0, 1);    // abort in lookup
        run_txn(16'h0c00, 1, 0, 2, 0, 1);    // abort in GFX access
        run_txn(16'h0100, 1, 0, 8, 0, 1);    // board read
        run_txn(16'h0200, 0, 7, 9, 0, 0);    // page table write

        for (int i = 0; i < 80; i++) begin
            a  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : pool[$urandom_range(0, 15)];
            rd = 1'($urandom);
            r  = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 80));
            pe = model(a, rd, r, 1000);
            if ($urandom_range(0, 3) == 0) ae = int'($urandom_range(1, pe.lat));
            else                           ae = pe.lat + 1 + int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 9) == 0);
            run_txn(a, rd, r, ae, rst, int'($urandom_range(0, 2)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        chk("monitor_idle", int'(mon_active), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
